// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : udp_pkg
// Description : Shared UDP/IP constants and the transmit-buffer read FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_pkg;

  localparam int MAX_UDP_PAYLOAD = 1472;
  localparam int UDP_HDR_LEN     = 8;
  localparam int IP_HDR_LEN      = 20;

  // Read-side FSM of udp_tx_buffer
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_XFER = 2'd2,
    RD_WAIT = 2'd3
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/udp_tx_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : udp_tx_buffer_if
// Description : Payload byte stream from user logic plus the request/data
//               handshake towards udp_send, bundled for udp_tx_buffer.
//               master = user logic + udp_send side, slave = the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_tx_buffer_if;

  // user payload stream
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  // udp_send handshake
  logic        start;
  logic [15:0] tx_data_len;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  data_o;

  modport master (
    output s_data, s_valid, s_last, busy, tx_dv,
    input  s_ready, start, tx_data_len, data_o
  );

  modport slave (
    input  s_data, s_valid, s_last, busy, tx_dv,
    output s_ready, start, tx_data_len, data_o
  );

endinterface
`default_nettype wire

// File: rtl/sdp_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_1r1w
// Description : Simple dual-port RAM, one write port and one registered read
//               port. Read-during-write to the same address returns old data.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_1r1w #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // registered read port; output register clears so the stage idles at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/udp_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_buffer
// Description : Store-and-forward packet buffer ahead of udp_send. Only
//               complete packets of at most MAX_LEN bytes are released; an
//               oversize packet is rolled back and counted as a drop. Each
//               stored packet launches one udp_send transfer and its bytes
//               are presented show-ahead on data_o, advancing on tx_dv.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_buffer
  import udp_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int LEN_DEPTH_W = 2,
  parameter int MAX_LEN     = MAX_UDP_PAYLOAD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  udp_tx_buffer_if.slave          bus,
  output logic                    drop,
  output logic [15:0]             drop_cnt
);

  localparam int                   c_LEN_DEPTH = 1 << LEN_DEPTH_W;
  localparam logic [LEN_DEPTH_W:0] c_LEN_FULL  = (LEN_DEPTH_W+1)'(c_LEN_DEPTH);
  localparam logic [15:0]          c_MAX_LEN   = 16'(MAX_LEN);

  localparam logic [1:0] c_ST_IDLE = RD_IDLE;
  localparam logic [1:0] c_ST_REQ  = RD_REQ;
  localparam logic [1:0] c_ST_XFER = RD_XFER;
  localparam logic [1:0] c_ST_WAIT = RD_WAIT;

  // write side
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_commit_ptr;
  logic [15:0]            r_wcnt;
  logic                   r_discard;
  logic                   r_drop;
  logic [15:0]            r_drop_cnt;

  // length FIFO
  logic [15:0]            r_len_mem [0:c_LEN_DEPTH-1];
  logic [LEN_DEPTH_W-1:0] r_len_wr;
  logic [LEN_DEPTH_W-1:0] r_len_rd;
  logic [LEN_DEPTH_W:0]   r_len_cnt;

  // read side
  logic [1:0]             r_state;
  logic                   r_armed;
  logic [15:0]            r_rem;
  logic [15:0]            r_tx_len;
  logic [ADDR_W-1:0]      r_rd_ptr;

  logic [ADDR_W-1:0]      w_wr_ptr_inc;
  logic [ADDR_W-1:0]      w_rd_ptr_next;
  logic                   w_byte_full;
  logic                   w_len_full;
  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_overflow;
  logic                   w_we;
  logic                   w_commit;
  logic                   w_drop_evt;
  logic                   w_byte_pop;
  logic                   w_len_pop;
  logic [15:0]            w_len_head;

  // Fullness is measured from the read pointer, so partially written packets
  // hold their space. One slot stays unused to tell full from empty.
  assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
  assign w_byte_full  = (w_wr_ptr_inc == r_rd_ptr);
  assign w_len_full   = (r_len_cnt == c_LEN_FULL);
  // A packet being discarded is always drained, since nothing gets stored.
  assign w_s_ready    = rst_n && (r_discard || (!w_byte_full && !w_len_full));
  assign w_accept     = bus.s_valid && w_s_ready;
  // The byte that would become number MAX_LEN+1 of the packet.
  assign w_overflow   = !r_discard && (r_wcnt == c_MAX_LEN);
  assign w_we         = w_accept && !r_discard && !w_overflow;
  assign w_commit     = w_we && bus.s_last;
  assign w_drop_evt   = w_accept && bus.s_last && (r_discard || w_overflow);

  assign w_len_head    = r_len_mem[r_len_rd];
  assign w_byte_pop    = (r_state == c_ST_XFER) && bus.tx_dv && (r_rem != 16'd0);
  assign w_len_pop     = (r_state == c_ST_XFER) && (r_rem == 16'd0);
  // RAM is addressed one step ahead so data_o tracks rd_ptr after each pop.
  assign w_rd_ptr_next = r_rd_ptr + {{(ADDR_W-1){1'b0}}, w_byte_pop};

  // write pointer, per-packet byte count, commit point and discard mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_wcnt       <= '0;
      r_discard    <= 1'b0;
    end else if (w_accept) begin
      if (r_discard) begin
        if (bus.s_last) begin
          r_discard <= 1'b0;
          r_wcnt    <= '0;
        end
      end else if (w_overflow) begin
        r_wr_ptr  <= r_commit_ptr;
        r_wcnt    <= '0;
        r_discard <= !bus.s_last;
      end else if (bus.s_last) begin
        r_wr_ptr     <= w_wr_ptr_inc;
        r_commit_ptr <= w_wr_ptr_inc;
        r_wcnt       <= '0;
      end else begin
        r_wr_ptr <= w_wr_ptr_inc;
        r_wcnt   <= r_wcnt + 16'd1;
      end
    end
  end

  // drop pulse and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_drop <= w_drop_evt;
      if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // length FIFO storage (contents need no reset, the count gates them)
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_len_mem[r_len_wr] <= r_wcnt + 16'd1;
    end
  end

  // length FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_wr  <= '0;
      r_len_rd  <= '0;
      r_len_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_len_wr <= r_len_wr + 1'b1;
      end
      if (w_len_pop) begin
        r_len_rd <= r_len_rd + 1'b1;
      end
      r_len_cnt <= r_len_cnt + {{LEN_DEPTH_W{1'b0}}, w_commit}
                             - {{LEN_DEPTH_W{1'b0}}, w_len_pop};
    end
  end

  // read FSM: one udp_send request per stored packet. start is held back one
  // cycle after REQ entry so the first byte is settled on data_o beforehand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_armed  <= 1'b0;
      r_rem    <= '0;
      r_tx_len <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_armed <= 1'b0;
      if (w_byte_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rem    <= r_rem - 16'd1;
      end
      case (r_state)
        c_ST_IDLE: begin
          if ((r_len_cnt != '0) && !bus.busy) begin
            r_rem    <= w_len_head;
            r_tx_len <= w_len_head;
            r_state  <= c_ST_REQ;
          end
        end
        c_ST_REQ: begin
          r_armed <= 1'b1;
          if (r_armed && bus.busy) begin
            r_state <= c_ST_XFER;
          end
        end
        c_ST_XFER: begin
          if (r_rem == 16'd0) begin
            r_state <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (!bus.busy) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  sdp_ram_1r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (bus.s_data),
    .raddr (w_rd_ptr_next),
    .rdata (bus.data_o)
  );

  assign bus.s_ready     = w_s_ready;
  assign bus.start       = (r_state == c_ST_REQ) && r_armed;
  assign bus.tx_data_len = r_tx_len;
  assign drop            = r_drop;
  assign drop_cnt        = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_buffer
// Description : Directed bench for udp_tx_buffer with a behavioural udp_send
//               responder and a byte/length scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_buffer;
  import udp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drop;
  logic [15:0] drop_cnt;

  udp_tx_buffer_if bus ();

  udp_tx_buffer #(
    .ADDR_W      (11),
    .LEN_DEPTH_W (2),
    .MAX_LEN     (MAX_UDP_PAYLOAD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop     (drop),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_bytes [$];
  int          exp_lens  [$];
  bit          hold = 1'b0;
  bit          in_xfer = 1'b0;
  bit          aborted = 1'b0;
  int          xfer_k = 0;
  int          pkts_done = 0;
  int          drop_seen = 0;
  time         t_pop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(seed + i + (i >> 8) * 7);
  endfunction

  // udp_send responder: busy for the whole transfer, tx_dv for len+1 cycles
  initial begin : udp_send_model
    int len;
    bus.busy  = 1'b0;
    bus.tx_dv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.busy  = 1'b0;
        bus.tx_dv = 1'b0;
      end else if (hold) begin
        bus.busy = 1'b1;
      end else if (bus.start && !bus.busy) begin
        chk("start_expected", exp_lens.size() != 0, 1);
        len = 0;
        if (exp_lens.size() != 0) len = exp_lens.pop_front();
        chk("tx_data_len", bus.tx_data_len, len);
        bus.busy = 1'b1;
        @(posedge clk); #1;
        chk("start_dropped_on_busy", bus.start, 0);
        in_xfer = 1'b1;
        for (int k = 0; k <= len; k++) begin
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          xfer_k = k;
          if (k < len) begin
            chk("byte_pending", exp_bytes.size() != 0, 1);
            if (exp_bytes.size() != 0) chk("data_o", bus.data_o, exp_bytes.pop_front());
          end
          bus.tx_dv = 1'b1;
          @(posedge clk); #1;
        end
        bus.tx_dv = 1'b0;
        bus.busy  = 1'b0;
        in_xfer   = 1'b0;
        if (aborted) begin
          exp_bytes.delete();
          exp_lens.delete();
        end else begin
          pkts_done++;
          t_pop = $time;
        end
      end else begin
        bus.busy = 1'b0;
      end
    end
  end

  // drop pulse counter
  initial begin : drop_monitor
    forever begin
      @(posedge clk); #1;
      if (drop === 1'b1) drop_seen++;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  task automatic put_byte(input logic [7:0] d, input logic last);
    int guard = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("s_ready_timeout", guard < 5000, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int seed, input bit keep);
    if (keep) exp_lens.push_back(len);
    for (int i = 0; i < len; i++) begin
      if (keep) exp_bytes.push_back(pat(seed, i));
      put_byte(pat(seed, i), i == len - 1);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_lens.size() != 0 || in_xfer || bus.busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n < budget, 1);
    chk({tag, "_bytes_left"}, exp_bytes.size(), 0);
  endtask

  initial begin : main
    int p0;
    int n;
    int starts;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_tx_data_len", bus.tx_data_len, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_drop", drop, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_after_reset", bus.s_ready, 1);

    // single 18-byte packet 0x00..0x11
    send_pkt(18, 0, 1'b1);
    wait_drain("pkt18", 500);
    chk("tx_len_held", bus.tx_data_len, 18);

    // back-to-back 10, 1, 1472
    send_pkt(10, 8'h40, 1'b1);
    send_pkt(1, 8'h80, 1'b1);
    send_pkt(1472, 8'h11, 1'b1);
    wait_drain("three_pkts", 6000);

    // oversize packets are dropped
    send_pkt(1473, 8'h22, 1'b0);
    send_pkt(5, 8'h33, 1'b1);
    wait_drain("drop1473", 3000);
    chk("drop_pulses_1", drop_seen, 1);
    chk("drop_cnt_1", drop_cnt, 1);
    send_pkt(1500, 8'h44, 1'b0);
    send_pkt(3, 8'h55, 1'b1);
    wait_drain("drop1500", 3000);
    chk("drop_pulses_2", drop_seen, 2);
    chk("drop_cnt_2", drop_cnt, 2);

    // length FIFO full with udp_send held busy
    hold = 1'b1;
    repeat (2) @(posedge clk);
    for (int p = 0; p < 4; p++) send_pkt(4, 8'h60 + p * 16, 1'b1);
    chk("len_full_s_ready", bus.s_ready, 0);
    repeat (4) @(negedge clk);
    chk("len_full_s_ready_held", bus.s_ready, 0);
    p0 = pkts_done;
    hold = 1'b0;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("len_full_ready_returns", n < 200, 1);
    chk("ready_after_first_pop_pkts", pkts_done, p0 + 1);
    chk("ready_after_first_pop_time", 32'($time - t_pop), 4);
    wait_drain("len_full", 1000);

    // byte storage filled to its 2047-byte limit
    hold = 1'b1;
    repeat (2) @(posedge clk);
    send_pkt(1472, 8'h03, 1'b1);
    send_pkt(500, 8'h05, 1'b1);
    exp_lens.push_back(200);
    for (int i = 0; i < 75; i++) begin
      exp_bytes.push_back(pat(8'h07, i));
      put_byte(pat(8'h07, i), 1'b0);
    end
    @(negedge clk);
    chk("byte_full_s_ready", bus.s_ready, 0);
    repeat (5) @(negedge clk);
    chk("byte_full_s_ready_held", bus.s_ready, 0);
    hold = 1'b0;
    for (int i = 75; i < 200; i++) begin
      exp_bytes.push_back(pat(8'h07, i));
      put_byte(pat(8'h07, i), i == 199);
    end
    wait_drain("byte_full", 6000);

    // reset in the middle of a 100-byte transfer
    send_pkt(100, 8'h09, 1'b1);
    n = 0;
    while (!(in_xfer && xfer_k >= 20) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_mid_xfer", n < 2000, 1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_s_ready", bus.s_ready, 0);
    chk("mid_rst_start", bus.start, 0);
    chk("mid_rst_tx_data_len", bus.tx_data_len, 0);
    chk("mid_rst_data_o", bus.data_o, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    starts = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.start === 1'b1) starts++;
    end
    chk("no_start_after_reset", starts, 0);
    chk("xfer_aborted", aborted, 1);
    send_pkt(6, 8'h21, 1'b1);
    wait_drain("post_reset_pkt", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
